// File: rtl/l1_layer_gen.sv
// Single-layer spiking-neuron block: per-synapse traces, weighted potentials,
// threshold decision (winner-take-all or multi-fire) and a fixed-latency output pipe.
module l1_layer_gen #(
    parameter int P_WIDTH = 9,
    parameter int P_SYN   = 4,
    parameter int P_NEU   = 6,
    parameter int P_DELAY = 1,
    localparam int LVW    = 2 * P_WIDTH + $clog2(P_SYN),
    localparam int IW     = $clog2(P_NEU)
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [P_SYN-1:0]             i_event,
    input  logic                         i_decay,
    input  logic                         i_mode,
    input  logic [P_NEU*P_SYN*P_WIDTH-1:0] i_weight,
    input  logic [P_NEU*LVW-1:0]         i_threshold,
    output logic [P_SYN*P_WIDTH-1:0]     o_tr,
    output logic [P_NEU*LVW-1:0]         o_lv,
    output logic [P_NEU-1:0]             o_spike,
    output logic [IW-1:0]                o_idx,
    output logic                         o_spike_valid,
    output logic                         o_nowin
);

    // Each stage carries a valid bit that follows the event through T -> L -> D -> delay
    // pipe; there is no back-pressure, so a decision is produced for every event cycle.
    logic [P_WIDTH-1:0] tr_q  [P_SYN];
    logic [LVW-1:0]     lv_q  [P_NEU];
    logic [LVW-1:0]     lv_sum[P_NEU];
    logic               ev_t_q;
    logic               ev_l_q;

    logic [LVW-1:0]     acc;
    logic [LVW-1:0]     best_lv;
    logic               found;
    logic [P_NEU-1:0]   cand;
    logic [P_NEU-1:0]   dec_spike;
    logic [IW-1:0]      dec_idx;

    logic [P_NEU-1:0]   spk_q [P_DELAY+1];
    logic [IW-1:0]      idx_q [P_DELAY+1];
    logic               val_q [P_DELAY+1];
    logic               nw_q  [P_DELAY+1];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int s = 0; s < P_SYN; s++) tr_q[s] <= '0;
            ev_t_q <= 1'b0;
        end else begin
            for (int s = 0; s < P_SYN; s++) begin
                if (i_event[s]) begin
                    tr_q[s] <= '1;
                end else if (i_decay && tr_q[s] != '0) begin
                    tr_q[s] <= tr_q[s] - 1'b1;
                end
            end
            ev_t_q <= |i_event;
        end
    end

    always_comb begin
        acc = '0;
        for (int n = 0; n < P_NEU; n++) begin
            acc = '0;
            for (int s = 0; s < P_SYN; s++) begin
                acc = acc + LVW'(tr_q[s]) * LVW'(i_weight[(n*P_SYN+s)*P_WIDTH +: P_WIDTH]);
            end
            lv_sum[n] = acc;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int n = 0; n < P_NEU; n++) lv_q[n] <= '0;
            ev_l_q <= 1'b0;
        end else begin
            if (ev_t_q) begin
                for (int n = 0; n < P_NEU; n++) lv_q[n] <= lv_sum[n];
            end
            ev_l_q <= ev_t_q;
        end
    end

    // Strict '>' while scanning upward keeps the lowest index on equal potentials.
    always_comb begin
        cand      = '0;
        dec_spike = '0;
        dec_idx   = '0;
        best_lv   = '0;
        found     = 1'b0;
        for (int n = 0; n < P_NEU; n++) begin
            cand[n] = (lv_q[n] >= i_threshold[n*LVW +: LVW]);
            if (cand[n]) begin
                if (i_mode) begin
                    if (!found) dec_idx = IW'(n);
                end else if (!found || lv_q[n] > best_lv) begin
                    best_lv = lv_q[n];
                    dec_idx = IW'(n);
                end
                found = 1'b1;
            end
        end
        if (i_mode) begin
            dec_spike = cand;
        end else if (found) begin
            dec_spike = {{(P_NEU-1){1'b0}}, 1'b1} << dec_idx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i <= P_DELAY; i++) begin
                spk_q[i] <= '0;
                idx_q[i] <= '0;
                val_q[i] <= 1'b0;
                nw_q[i]  <= 1'b0;
            end
        end else begin
            spk_q[0] <= ev_l_q ? dec_spike : '0;
            idx_q[0] <= (ev_l_q && found) ? dec_idx : '0;
            val_q[0] <= ev_l_q && found;
            nw_q[0]  <= ev_l_q && !found;
            for (int i = 1; i <= P_DELAY; i++) begin
                spk_q[i] <= spk_q[i-1];
                idx_q[i] <= idx_q[i-1];
                val_q[i] <= val_q[i-1];
                nw_q[i]  <= nw_q[i-1];
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < P_SYN; g++) begin : g_tr
            assign o_tr[g*P_WIDTH +: P_WIDTH] = tr_q[g];
        end
        for (g = 0; g < P_NEU; g++) begin : g_lv
            assign o_lv[g*LVW +: LVW] = lv_q[g];
        end
    endgenerate

    assign o_spike       = spk_q[P_DELAY];
    assign o_idx         = idx_q[P_DELAY];
    assign o_spike_valid = val_q[P_DELAY];
    assign o_nowin       = nw_q[P_DELAY];

endmodule

// File: tb/tb_l1_layer_gen.sv
// Bench for l1_layer_gen: trace/potential spot checks per scenario plus a
// scoreboard of expected decision pulses keyed by the cycle they must appear in.
module tb_l1_layer_gen;

    localparam int W   = 4;
    localparam int S   = 4;
    localparam int N   = 6;
    localparam int D   = 1;
    localparam int LVW = 2 * W + $clog2(S);
    localparam int IW  = $clog2(N);
    localparam int LAT = 3 + D;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [S-1:0]         ev;
    logic                 decay;
    logic                 mode;
    logic [N*S*W-1:0]     weight;
    logic [N*LVW-1:0]     threshold;
    logic [S*W-1:0]       tr;
    logic [N*LVW-1:0]     lv;
    logic [N-1:0]         spike;
    logic [IW-1:0]        idx;
    logic                 spike_valid;
    logic                 nowin;

    l1_layer_gen #(.P_WIDTH(W), .P_SYN(S), .P_NEU(N), .P_DELAY(D)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_event(ev), .i_decay(decay), .i_mode(mode),
        .i_weight(weight), .i_threshold(threshold), .o_tr(tr), .o_lv(lv),
        .o_spike(spike), .o_idx(idx), .o_spike_valid(spike_valid), .o_nowin(nowin)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [10:0] exp_q[$];
    int          due_q[$];
    bit          mon_en = 1'b0;
    logic [10:0] e;

    int m_tr[S];
    int w_m[N][S];
    int th_m[N];

    // Expected word: {spike[5:0], idx[2:0], valid, nowin}
    function automatic logic [10:0] model_decide();
        int       lvv;
        int       best;
        int       best_i;
        int       first;
        bit       any;
        logic [N-1:0] c;
        logic [N-1:0] sp;
        c = '0; any = 1'b0; best = -1; best_i = 0; first = 0;
        for (int n = 0; n < N; n++) begin
            lvv = 0;
            for (int s = 0; s < S; s++) lvv += m_tr[s] * w_m[n][s];
            if (lvv >= th_m[n]) begin
                c[n] = 1'b1;
                if (!any) first = n;
                any = 1'b1;
                if (lvv > best) begin
                    best = lvv;
                    best_i = n;
                end
            end
        end
        if (!any) return {6'b0, 3'b0, 1'b0, 1'b1};
        if (mode) return {c, 3'(first), 1'b1, 1'b0};
        sp = 6'(1 << best_i);
        return {sp, 3'(best_i), 1'b1, 1'b0};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply_params();
        for (int n = 0; n < N; n++) begin
            threshold[n*LVW +: LVW] = LVW'(th_m[n]);
            for (int s = 0; s < S; s++) weight[(n*S+s)*W +: W] = W'(w_m[n][s]);
        end
    endtask

    task automatic set_weights(input int base, input int n_a, input int n_b, input int big, input int th);
        for (int n = 0; n < N; n++) begin
            th_m[n] = th;
            for (int s = 0; s < S; s++) w_m[n][s] = base;
        end
        w_m[n_a][0] = big;
        w_m[n_b][0] = big;
        apply_params();
    endtask

    // Called just after a rising edge; the inputs are sampled by the next edge.
    task automatic cyc_drive(input logic [S-1:0] e_in, input logic d_in);
        ev = e_in;
        decay = d_in;
        for (int s = 0; s < S; s++) begin
            if (e_in[s]) m_tr[s] = 15;
            else if (d_in && m_tr[s] > 0) m_tr[s] = m_tr[s] - 1;
        end
        if (e_in != '0) begin
            exp_q.push_back(model_decide());
            due_q.push_back(cyc + LAT);
        end
        @(posedge clk); #1;
        ev = '0;
        decay = 1'b0;
    endtask

    // ---------------- output monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (due_q.size() > 0 && due_q[0] == cyc) begin
                e = exp_q.pop_front();
                void'(due_q.pop_front());
                checks++;
                if (spike !== e[10:5] || spike_valid !== e[1] || nowin !== e[0] ||
                    (e[1] && idx !== e[4:2])) begin
                    errors++;
                    $display("FAIL decision cyc=%0d got spike=%b idx=%0d v=%b nw=%b want spike=%b idx=%0d v=%b nw=%b",
                             cyc, spike, idx, spike_valid, nowin, e[10:5], e[4:2], e[1], e[0]);
                end
            end else if (spike !== '0 || spike_valid !== 1'b0 || nowin !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pulse cyc=%0d got spike=%b v=%b nw=%b want all 0",
                         cyc, spike, spike_valid, nowin);
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; ev = '0; decay = 1'b0; mode = 1'b0;
        for (int s = 0; s < S; s++) m_tr[s] = 0;
        set_weights(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tr !== '0) begin errors++; $display("FAIL reset_tr got %h want 0", tr); end
        checks++; if (lv !== '0) begin errors++; $display("FAIL reset_lv got %h want 0", lv); end
        checks++;
        if (spike !== '0 || idx !== '0 || spike_valid !== 1'b0 || nowin !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got spike=%b idx=%0d v=%b nw=%b want 0", spike, idx, spike_valid, nowin);
        end
        rst_n = 1'b1;
        mon_en = 1'b1;
    endtask

    task automatic test_wta_hit();
        mode = 1'b0;
        set_weights(2, 3, 3, 10, 100);
        cyc_drive(4'b0001, 1'b0);
        checks++; if (tr[3:0] !== 4'd15) begin errors++; $display("FAIL wta_tr0 got %0d want 15", tr[3:0]); end
        @(posedge clk); #1;
        checks++; if (lv[3*LVW +: LVW] !== 10'd150) begin errors++; $display("FAIL wta_lv3 got %0d want 150", lv[3*LVW +: LVW]); end
        checks++; if (lv[0 +: LVW] !== 10'd30) begin errors++; $display("FAIL wta_lv0 got %0d want 30", lv[0 +: LVW]); end
        repeat (LAT + 1) @(posedge clk); #1;
    endtask

    task automatic test_no_winner();
        set_weights(2, 3, 3, 10, 200);
        cyc_drive(4'b0001, 1'b0);
        repeat (LAT + 2) @(posedge clk); #1;
    endtask

    task automatic test_tie_mode();
        set_weights(2, 2, 5, 10, 100);
        mode = 1'b0;
        cyc_drive(4'b0001, 1'b0);
        @(posedge clk); #1;
        checks++;
        if (lv[2*LVW +: LVW] !== 10'd150 || lv[5*LVW +: LVW] !== 10'd150) begin
            errors++;
            $display("FAIL tie_lv got %0d/%0d want 150/150", lv[2*LVW +: LVW], lv[5*LVW +: LVW]);
        end
        repeat (LAT + 1) @(posedge clk); #1;
        mode = 1'b1;
        cyc_drive(4'b0001, 1'b0);
        repeat (LAT + 2) @(posedge clk); #1;
        mode = 1'b0;
    endtask

    task automatic test_decay();
        set_weights(2, 3, 3, 10, 1023);
        cyc_drive(4'b0010, 1'b0);
        checks++; if (tr[7:4] !== 4'd15) begin errors++; $display("FAIL decay_load got %0d want 15", tr[7:4]); end
        repeat (3) cyc_drive(4'b0000, 1'b1);
        checks++; if (tr[7:4] !== 4'd12) begin errors++; $display("FAIL decay_3 got %0d want 12", tr[7:4]); end
        cyc_drive(4'b0010, 1'b1);
        checks++; if (tr[7:4] !== 4'd15) begin errors++; $display("FAIL decay_evwins got %0d want 15", tr[7:4]); end
        repeat (20) cyc_drive(4'b0000, 1'b1);
        checks++; if (tr[7:4] !== 4'd0) begin errors++; $display("FAIL decay_sat got %0d want 0", tr[7:4]); end
        checks++; if (tr !== '0) begin errors++; $display("FAIL decay_all got %h want 0", tr); end
        repeat (LAT + 2) @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        set_weights(2, 3, 3, 10, 100);
        cyc_drive(4'b0001, 1'b0);
        cyc_drive(4'b0010, 1'b0);
        cyc_drive(4'b0100, 1'b0);
        repeat (LAT + 2) @(posedge clk); #1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL b2b_drain got %0d want 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        set_weights(2, 3, 3, 10, 100);
        cyc_drive(4'b0001, 1'b0);
        cyc_drive(4'b0001, 1'b0);
        rst_n = 1'b0;
        exp_q.delete();
        due_q.delete();
        for (int s = 0; s < S; s++) m_tr[s] = 0;
        @(posedge clk); #1;
        checks++;
        if (spike !== '0 || idx !== '0 || spike_valid !== 1'b0 || nowin !== 1'b0 || tr !== '0 || lv !== '0) begin
            errors++;
            $display("FAIL midreset_out got spike=%b idx=%0d v=%b nw=%b tr=%h lv=%h want 0",
                     spike, idx, spike_valid, nowin, tr, lv);
        end
        rst_n = 1'b1;
        cyc_drive(4'b0001, 1'b0);
        checks++; if (tr[3:0] !== 4'd15) begin errors++; $display("FAIL first_edge_tr got %0d want 15", tr[3:0]); end
        repeat (LAT + 3) @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int it = 0; it < 30; it++) begin
            for (int n = 0; n < N; n++) begin
                th_m[n] = $urandom_range(0, 400);
                for (int s = 0; s < S; s++) w_m[n][s] = $urandom_range(0, 15);
            end
            apply_params();
            mode = 1'($urandom_range(0, 1));
            for (int c = 0; c < 4; c++) begin
                cyc_drive(S'($urandom_range(0, (1 << S) - 1)), 1'($urandom_range(0, 1)));
            end
            repeat (LAT + 1) @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_wta_hit();
        test_no_winner();
        test_tie_mode();
        test_decay();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        repeat (2) @(posedge clk); #1;
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL final_drain got %0d want 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
